eth_stats_frame_meter: RTL
==========================

Name: eth_stats_frame_meter

Overview:
- Passive per-frame meter on a byte-wide AXI4-Stream receive/transmit tap. It sits directly upstream of the statistics adder.
- For every completed frame it emits one single-cycle result: a `valid` pulse with `frame_length` and `frame_good`.
- The adder accumulates these results into byte, good-frame and bad-frame totals.
- The block never drives `tready`; it only observes handshakes.

Parameters:
- MIN_LEN, 64, minimum length in bytes for a good frame (inclusive).
- MAX_LEN, 1518, maximum length in bytes for a good frame (inclusive); legal range MIN_LEN..16383.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  counting enable, sampled on the first beat of each frame.
- s_axis_tvalid  input  1  observed stream valid.
- s_axis_tready  input  1  observed stream ready.
- s_axis_tlast  input  1  last beat of frame.
- s_axis_tuser  input  1  frame error flag (MAC FCS/PHY error); may be asserted on any beat.
- valid  output  1  one-cycle pulse: one frame result is available.
- frame_length  output  14  frame byte count, saturated at 16383.
- frame_good  output  1  1 = frame error-free and within MIN_LEN..MAX_LEN.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Beat definition: a beat is a cycle with `s_axis_tvalid & s_axis_tready`. Each beat is one byte.
- Reset values:
  - `valid`=0, `frame_length`=0, `frame_good`=0.
  - Internal byte counter = 0, error flag = 0, state = IDLE.
- IDLE:
  - On a beat with `enable`=1 and `tlast`=0: counter := 1, err := `tuser`, go to COUNT.
  - On a beat with `enable`=1 and `tlast`=1: single-byte frame; emit result directly (length 1), stay in IDLE.
  - On a beat with `enable`=0 and `tlast`=0: go to SKIP.
  - On a beat with `enable`=0 and `tlast`=1: frame ignored, stay in IDLE.
- COUNT:
  - Each beat: counter := sat(counter+1), err := err | `tuser`.
  - On a beat with `tlast`=1: emit result, go to IDLE.
  - `enable` is ignored while in COUNT; a frame started counted is always reported.
- SKIP:
  - Beats are ignored. On a beat with `tlast`=1, go to IDLE. No result is produced.
- Result emission:
  - Registered: `valid`=1 in the cycle after the tlast beat, for exactly one cycle.
  - `frame_length` = total beats including the last beat, saturated at 16383.
  - `frame_good` = ~err_total & (len ≥ MIN_LEN) & (len ≤ MAX_LEN), where err_total includes `tuser` on the last beat.
  - `frame_length`/`frame_good` hold their value until the next emission. They are meaningful only while `valid`=1.
- Saturation: the counter stops at 16383 and does not wrap. A saturated frame is bad whenever MAX_LEN < 16383.
- Back-to-back frames: a tlast beat followed in the very next cycle by a new first beat is legal. The new frame starts at count 1 and the previous result still pulses. Sustained throughput is one frame per 1 beat.
- Gaps: cycles with `tvalid`=0 or `tready`=0 inside a frame do not advance the counter and do not sample `tuser`.
- Reset mid-frame: the partial frame is discarded and no result is emitted. Afterwards the block sits in IDLE, and the next beat seen is treated as a frame start. A trailing partial frame may therefore be reported as a short (bad) frame; this is accepted.
- Reset coincident with a tlast beat: reset wins; no pulse.
- Enable at the downstream stage: `valid` may pulse after `enable` has dropped. The downstream adder's own enable gating decides whether that result is accumulated.

Test Plan:
- 64-byte frame, `enable`=1, `tuser`=0, continuous beats → one `valid` pulse one cycle after tlast; `frame_length`=64, `frame_good`=1.
- 100-byte frame with `tuser`=1 on beat 50 only, plus `tvalid`/`tready` gaps every 3rd cycle → `frame_length`=100, `frame_good`=0, exactly one pulse.
- Back-to-back frames of 60 and 1519 bytes with no idle cycle between them → two pulses: (60, good=0) then (1519, good=0). Repeat with 1518 → good=1.
- 20000-byte frame → `frame_length`=16383, `frame_good`=0, no wrap.
- `enable`=0 at the first beat, raised mid-frame → no pulse for that frame; the next frame (`enable`=1, 64 bytes) reports (64, 1).
- `rst` asserted at beat 30 of a 64-byte frame → no pulse, all outputs 0. Next full 64-byte frame reports (64, 1). Single-beat frame → (1, 0).

Source files
------------

// File: rtl/eth_stats_frame_meter_if.sv
// rtl/eth_stats_frame_meter_if.sv - byte-wide stream tap bundle for the frame meter
interface eth_stats_frame_meter_if;
    logic tvalid;
    logic tready;
    logic tlast;
    logic tuser;

    modport master (output tvalid, output tlast, output tuser, input tready);
    modport slave (input tvalid, input tlast, input tuser, output tready);
    // Passive observer: sees both sides of the handshake, drives nothing.
    modport monitor (input tvalid, input tready, input tlast, input tuser);
endinterface

// File: rtl/eth_stats_frame_meter.sv
// rtl/eth_stats_frame_meter.sv - per-frame length/quality meter on a stream tap
module eth_stats_frame_meter #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    eth_stats_frame_meter_if.monitor         s_axis,
    output logic                             valid,
    output logic [13:0]                      frame_length,
    output logic                             frame_good
);

    localparam logic [13:0] LEN_SAT = 14'h3FFF;
    localparam logic [13:0] MIN_L   = 14'(MIN_LEN);
    localparam logic [13:0] MAX_L   = 14'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SKIP  = 2'd2
    } state_t;

    state_t      state;
    logic [13:0] cnt;
    logic        err;

    logic        beat;
    logic [13:0] cnt_inc;
    logic        err_total;

    assign beat      = s_axis.tvalid & s_axis.tready;
    // Counter sticks at the top value instead of wrapping.
    assign cnt_inc   = (cnt == LEN_SAT) ? LEN_SAT : cnt + 14'd1;
    assign err_total = err | s_axis.tuser;

    function automatic logic judge(input logic [13:0] len, input logic e);
        return !e && (len >= MIN_L) && (len <= MAX_L);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 14'd0;
            err          <= 1'b0;
            valid        <= 1'b0;
            frame_length <= 14'd0;
            frame_good   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (beat) begin
                        if (enable) begin
                            if (s_axis.tlast) begin
                                valid        <= 1'b1;
                                frame_length <= 14'd1;
                                frame_good   <= judge(14'd1, s_axis.tuser);
                            end else begin
                                cnt   <= 14'd1;
                                err   <= s_axis.tuser;
                                state <= COUNT;
                            end
                        end else if (!s_axis.tlast) begin
                            state <= SKIP;
                        end
                    end
                end
                // Enable is deliberately not looked at here: a counted frame always reports.
                COUNT: begin
                    if (beat) begin
                        if (s_axis.tlast) begin
                            valid        <= 1'b1;
                            frame_length <= cnt_inc;
                            frame_good   <= judge(cnt_inc, err_total);
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt_inc;
                            err <= err_total;
                        end
                    end
                end
                SKIP: begin
                    if (beat && s_axis.tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
